// File: rtl/mem_bridge.sv
// mem_bridge: CPU data-port bridge to a byte-lane RAM and a timer block.
// Ports: clk, reset (async, active-low), m_data_addr/wdata/byteen in,
//        m_data_rdata (combinational read data), irq (registered timer irq).
module mem_bridge #(
    parameter int          RAM_WORDS  = 3072,
    parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    output logic [31:0] m_data_rdata,
    output logic        irq
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    logic [31:0] ram [RAM_WORDS];

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irqf;

    logic [3:0]  ctrl_nxt;
    logic        irqf_nxt;

    logic [29:0]   word_addr;
    logic [AW-1:0] widx;
    logic          ram_sel;
    logic          sel_ctrl;
    logic          sel_preset;
    logic          sel_count;
    logic          wr_full;
    logic          wr_ctrl;
    logic          wr_preset;
    logic          auto_reload;
    logic          unused_addr_lsb;

    assign word_addr  = m_data_addr[31:2];
    assign widx       = m_data_addr[AW+1:2];
    assign ram_sel    = m_data_addr < RAM_BYTES;
    assign sel_ctrl   = word_addr == TIMER_BASE[31:2];
    assign sel_preset = word_addr == TIMER_BASE[31:2] + 30'd1;
    assign sel_count  = word_addr == TIMER_BASE[31:2] + 30'd2;

    // Timer registers only take whole-word stores.
    assign wr_full   = &m_data_byteen;
    assign wr_ctrl   = wr_full & sel_ctrl;
    assign wr_preset = wr_full & sel_preset;

    // MODE 1x behaves like one-shot.
    assign auto_reload = ctrl[2:1] == 2'b01;

    assign unused_addr_lsb = ^m_data_addr[1:0];

    // RAM is deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (m_data_byteen[i]) begin
                    ram[widx][8*i +: 8] <= m_data_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        m_data_rdata = '0;
        if (ram_sel) begin
            m_data_rdata = ram[widx];
        end else if (sel_ctrl) begin
            m_data_rdata = {28'b0, ctrl};
        end else if (sel_preset) begin
            m_data_rdata = preset;
        end else if (sel_count) begin
            m_data_rdata = count;
        end
    end

    // Ordering sets priority: the INT side effects, then a CPU CTRL
    // write (which also acks the flag), then a fresh INT entry.
    always_comb begin
        ctrl_nxt = ctrl;
        irqf_nxt = irqf;
        if (state == S_INT) begin
            if (auto_reload) begin
                irqf_nxt = 1'b0;
            end else begin
                ctrl_nxt[0] = 1'b0;
            end
        end
        if (wr_ctrl) begin
            ctrl_nxt = m_data_wdata[3:0];
            irqf_nxt = 1'b0;
        end
        if (state == S_CNT && ctrl[0] && count == '0) begin
            irqf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            ctrl   <= '0;
            preset <= '0;
            count  <= '0;
            irqf   <= 1'b0;
            irq    <= 1'b0;
        end else begin
            ctrl <= ctrl_nxt;
            irqf <= irqf_nxt;
            // Registered, but from next-state values so irq
            // rises on the same edge that enters INT.
            irq  <= irqf_nxt & ctrl_nxt[3];
            if (wr_preset) begin
                preset <= m_data_wdata;
            end
            case (state)
                S_IDLE: begin
                    if (ctrl[0]) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!ctrl[0]) begin
                        state <= S_IDLE;
                    end else if (count == '0) begin
                        state <= S_INT;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                S_INT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed + randomized self-checking bench for mem_bridge.
// RAM is checked against a word array model, the timer against its timing rules.
module tb_mem_bridge;

    localparam int          RAM_WORDS = 3072;
    localparam logic [31:0] TB_BASE   = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL    = TB_BASE;
    localparam logic [31:0] A_PRESET  = TB_BASE + 32'd4;
    localparam logic [31:0] A_COUNT   = TB_BASE + 32'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic [31:0] rdata;
    logic        irq;

    int n_assert = 0;
    int n_fail = 0;

    logic [31:0] ram_m [int];

    mem_bridge #(
        .RAM_WORDS (RAM_WORDS),
        .TIMER_BASE(TB_BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m_data_addr  (addr),
        .m_data_wdata (wdata),
        .m_data_byteen(be),
        .m_data_rdata (rdata),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b);
        @(negedge clk);
        addr = a;
        wdata = d;
        be = b;
        @(posedge clk);
        #1;
        be = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        chk(tag, v, exp);
    endtask

    task automatic stop_timer();
        wr(A_CTRL, 32'h0, 4'hF);
        repeat (4) tick();
    endtask

    task automatic ram_write(input int idx, input logic [31:0] d,
                             input logic [3:0] b);
        logic [31:0] w;
        wr(32'(idx * 4), d, b);
        w = ram_m.exists(idx) ? ram_m[idx] : 32'h0;
        for (int l = 0; l < 4; l++) begin
            if (b[l]) w[8*l +: 8] = d[8*l +: 8];
        end
        ram_m[idx] = w;
    endtask

    // Auto-reload: first INT P+3 edges after the CTRL write,
    // then one every P+4 edges.
    task automatic run_auto(input int p, input logic [31:0] c,
                            input int cycles);
        logic e;
        wr(A_PRESET, 32'(p), 4'hF);
        wr(A_CTRL, c, 4'hF);
        for (int t = 1; t <= cycles; t++) begin
            tick();
            e = c[3] && t >= p + 3 && ((t - p - 3) % (p + 4)) == 0;
            chk("auto_irq", 32'(irq), 32'(e));
        end
        stop_timer();
    endtask

    initial begin
        logic [31:0] v;
        bit          found;
        int          p;
        int          idx;

        // Reset state, before any clock edge.
        #2;
        chk("rst_irq", 32'(irq), 32'h0);
        chk_rd("rst_ctrl", A_CTRL, 32'h0);
        chk_rd("rst_preset", A_PRESET, 32'h0);
        chk_rd("rst_count", A_COUNT, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Byte-lane RAM writes.
        ram_write(4, 32'hAABBCCDD, 4'hF);
        ram_write(4, 32'h11223344, 4'h5);
        chk_rd("ram_lanes", 32'h10, 32'hAA22CC44);
        chk_rd("ram_lsb_ign", 32'h13, 32'hAA22CC44);

        // Random RAM traffic, low words and the top of the map.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0)
                idx = RAM_WORDS - 1 - int'($urandom_range(0, 3));
            else
                idx = int'($urandom_range(0, 15));
            if (!ram_m.exists(idx))
                ram_write(idx, $urandom, 4'hF);
            ram_write(idx, $urandom, 4'($urandom_range(1, 15)));
        end
        foreach (ram_m[k]) chk_rd("ram_rand", 32'(k * 4), ram_m[k]);
        wr(32'(4 * RAM_WORDS), 32'hDEADBEEF, 4'hF);
        chk_rd("ram_past_end", 32'(4 * RAM_WORDS), 32'h0);

        // One-shot, PRESET=3, CTRL=0x9.
        wr(A_PRESET, 32'd3, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        addr = A_COUNT;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (t <= 5) begin
                v = (t == 1) ? 32'd0 : 32'(5 - t);
                chk("os_count", rdata, v);
            end
            chk("os_irq", 32'(irq), 32'(t >= 6));
        end
        chk_rd("os_ctrl_en_clr", A_CTRL, 32'h8);
        repeat (3) tick();
        chk("os_irq_sticky", 32'(irq), 32'h1);
        wr(A_CTRL, 32'h8, 4'hF);
        chk("os_irq_ack", 32'(irq), 32'h0);
        tick();
        chk("os_irq_ack2", 32'(irq), 32'h0);

        // One-shot with random PRESET.
        p = int'($urandom_range(0, 6));
        wr(A_PRESET, 32'(p), 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        for (int t = 1; t <= p + 3; t++) begin
            tick();
            chk("os_rand_irq", 32'(irq), 32'(t == p + 3));
        end
        stop_timer();

        // CPU write to CTRL on the INT edge wins over EN clear.
        wr(A_PRESET, 32'd1, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        repeat (4) tick();
        chk("race_irq_set", 32'(irq), 32'h1);
        wr(A_CTRL, 32'h9, 4'hF);
        chk_rd("race_ctrl", A_CTRL, 32'h9);
        chk("race_irq_ack", 32'(irq), 32'h0);
        stop_timer();

        // Auto-reload.
        run_auto(2, 32'hB, 20);
        run_auto(int'($urandom_range(0, 5)), 32'hB, 24);
        run_auto(2, 32'h3, 20);

        // Disable mid-count.
        wr(A_PRESET, 32'd10, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            rd(A_COUNT, v);
            if (v == 32'd6) found = 1;
        end
        chk("dis_poll", 32'(found), 32'h1);
        wr(A_CTRL, 32'h8, 4'hF);
        repeat (5) tick();
        chk_rd("dis_count", A_COUNT, 32'd5);
        chk("dis_irq", 32'(irq), 32'h0);

        // Ignored writes and unmapped reads.
        wr(A_COUNT, 32'hFFFFFFFF, 4'hF);
        chk_rd("ro_count", A_COUNT, 32'd5);
        wr(A_PRESET, 32'h1234, 4'h3);
        chk_rd("half_preset", A_PRESET, 32'd10);
        wr(A_CTRL, 32'h1, 4'h7);
        chk_rd("part_ctrl", A_CTRL, 32'h8);
        wr(32'h5000, 32'hCAFEF00D, 4'hF);
        chk_rd("unmapped", 32'h5000, 32'h0);
        chk_rd("unmapped_tmr", TB_BASE + 32'hC, 32'h0);

        // Asynchronous reset mid-count.
        wr(A_PRESET, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            rd(A_COUNT, v);
            if (v == 32'd2) found = 1;
        end
        chk("rst_poll", 32'(found), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_irq", 32'(irq), 32'h0);
        chk_rd("arst_ctrl", A_CTRL, 32'h0);
        chk_rd("arst_preset", A_PRESET, 32'h0);
        chk_rd("arst_count", A_COUNT, 32'h0);
        chk_rd("arst_ram", 32'h10, ram_m[4]);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) tick();
        chk("post_irq", 32'(irq), 32'h0);
        chk_rd("post_count", A_COUNT, 32'h0);
        chk_rd("post_ctrl", A_CTRL, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter RAM_WORDS, default 3072, number of 32-bit RAM words mapped from address 0x0000_0000.
REQ-002 Parameter TIMER_BASE, default 32'h0000_7F00, base address of the timer register block.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 m_data_addr  input  32  byte address from the CPU data port; bits [1:0] ignored.
REQ-006 m_data_wdata  input  32  write data, already lane-aligned by the CPU.
REQ-007 m_data_byteen  input  4  per-lane write enable; 4'b0000 means a read or idle cycle.
REQ-008 m_data_rdata  output  32  read data, combinational from m_data_addr.
REQ-009 irq  output  1  timer interrupt request, registered.

Function
REQ-010 Address map: RAM at 0x0000_0000 to 4*RAM_WORDS-1; CTRL at TIMER_BASE+0; PRESET at TIMER_BASE+4; COUNT at TIMER_BASE+8 (read-only); all other addresses read 0 and ignore writes.
REQ-011 RAM write: at the clock edge, each lane i with m_data_byteen[i]=1 writes m_data_wdata[8i+7:8i]; lanes with enable 0 are unchanged.
REQ-012 Timer registers accept only full-word writes (byteen=4'b1111); partial writes are ignored.
REQ-013 CTRL fields: bit0 EN; bits2:1 MODE (00 one-shot, 01 auto-reload, 1x treated as 00); bit3 IM (interrupt mask); reads return {28'b0,CTRL[3:0]}.
REQ-014 Timer FSM states: IDLE, LOAD, CNT, INT.
REQ-015 IDLE: EN=1 -> LOAD; otherwise stay.
REQ-016 LOAD: COUNT<=PRESET; -> CNT.
REQ-017 CNT: EN=0 -> IDLE with COUNT held; else COUNT=0 -> INT; else COUNT<=COUNT-1.
REQ-018 Entry to INT sets the internal flag IRQF in the same edge.
REQ-019 INT, MODE 00: clear CTRL.EN; -> IDLE; IRQF stays set until the next full-word CPU write to CTRL.
REQ-020 INT, MODE 01: -> IDLE; IRQF cleared on leaving INT (high exactly one cycle); period INT-to-INT = PRESET+4 cycles.
REQ-021 irq = IRQF & CTRL.IM, registered.
REQ-022 CPU write to CTRL in the same cycle that INT clears EN: the CPU value wins.
REQ-023 PRESET writes during CNT do not affect COUNT until the next LOAD.
REQ-024 COUNT never wraps: the decrement is suppressed at 0.

Reset
REQ-025 With reset=0: CTRL, PRESET, COUNT = 0; FSM = IDLE; IRQF and irq = 0, taking effect immediately without a clock edge.
REQ-026 RAM contents are not reset.
REQ-027 Reset asserted mid-count aborts the count with no irq; after release the timer idles until EN is written.

Verification
REQ-028 Write 0xAABBCCDD to 0x10 with byteen=1111, then 0x11223344 with byteen=0101 -> a read of 0x10 returns 0xAA22CC44.
REQ-029 PRESET=3, CTRL=0x9 written at edge k -> LOAD at k+1, COUNT 3/2/1/0 at k+2..k+5, INT and irq=1 at k+6, CTRL reads 0x8 after k+7, irq stays 1 until CTRL is rewritten.
REQ-030 PRESET=2, CTRL=0xB (auto-reload, IM) -> irq pulses one cycle every 6 cycles; with CTRL=0x3 (IM=0) no irq is seen.
REQ-031 Write CTRL=0x8 during CNT with COUNT=5 -> IDLE next cycle, COUNT holds 5, no irq.
REQ-032 Write to 0x7F08 and a half-word write to 0x7F04 -> COUNT and PRESET are unchanged; a read of 0x5000 returns 0.
REQ-033 Assert reset at COUNT=2 between edges -> irq=0 and all registers read 0 immediately; RAM data written earlier is still readable.
